sentinel_seq_lock: RTL and testbench
====================================

SENTINEL_SEQ_LOCK -- requirements
Module: sentinel_seq_lock

Interface
REQ-001 Parameters SHALL be: KEY_W 8, width of one key symbol; SEQ_LEN 4, symbols per code; KEY_SEQ {8'h0F,8'hC3,8'h5A,8'hB6}, packed code with symbol i = KEY_SEQ[i*KEY_W +: KEY_W] and symbol 0 entered first; MAX_FAILS 3, consecutive failures before lockout; LOCKOUT_CYCLES 1024, lockout duration; TIMEOUT_CYCLES 256, maximum inter-symbol gap; AUTO_RELOCK 0, cycles in UNLOCKED before automatic relock (0 = never).
REQ-002 Ports SHALL be:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  power-state enable.
- key_in  in  KEY_W  key symbol.
- key_valid  in  1  symbol strobe, one symbol per high cycle.
- key_ready  out  1  symbol acceptance possible (LOCKED or COLLECT).
- relock  in  1  synchronous relock request.
- glitch  in  1  glitch-detector alarm, active high.
- seg_out  out  8  7-segment {dp,g,f,e,d,c,b,a}, active low.
- unlocked  out  1  high in UNLOCKED only.
- alarm  out  1  high in LOCKOUT only.
- fail_cnt  out  $clog2(MAX_FAILS+1)  consecutive failure count.

Function
REQ-003 FSM states SHALL be LOCKED, COLLECT, UNLOCKED, LOCKOUT; a symbol is accepted when key_valid=1 and key_ready=1 at a rising edge.
REQ-004 LOCKED: accepting a symbol SHALL load index=1, set mismatch=(key_in!=symbol 0), and enter COLLECT, except that when SEQ_LEN=1 the decision in REQ-006 is applied immediately.
REQ-005 COLLECT: each accepted symbol SHALL OR (key_in!=symbol index) into mismatch and increment index; no early abort on mismatch (constant-time entry).
REQ-006 The accepted symbol with index=SEQ_LEN-1 SHALL decide at that edge: mismatch clear goes to UNLOCKED and fail_cnt=0; otherwise fail_cnt increments and the FSM goes to LOCKOUT if the new fail_cnt equals MAX_FAILS, else to LOCKED.
REQ-007 COLLECT: TIMEOUT_CYCLES consecutive cycles with no accepted symbol SHALL count as a failure under REQ-006 rules; a key_valid arriving in the expiry cycle SHALL be accepted instead, and no timeout SHALL be taken.
REQ-008 UNLOCKED: key_valid SHALL be ignored; relock=1 SHALL go to LOCKED; if AUTO_RELOCK>0, the FSM SHALL go to LOCKED after AUTO_RELOCK cycles in UNLOCKED.
REQ-009 LOCKOUT: key_valid SHALL be ignored and key_ready=0; after LOCKOUT_CYCLES cycles the FSM SHALL go to LOCKED with fail_cnt=0; relock SHALL have no effect.
REQ-010 glitch=1 SHALL, at that edge, take priority over all other inputs, clear index and mismatch, set fail_cnt=MAX_FAILS, and enter LOCKOUT with a fresh full lockout count.
REQ-011 Priority SHALL be glitch > relock > timer expiry > key_valid.
REQ-012 unlocked, alarm, key_ready, and seg_out SHALL decode combinationally from the state register only; the final correct symbol sampled at edge N SHALL give unlocked=1 from edge N.
REQ-013 When ena=1, seg_out SHALL be LOCKED 8'hC7 ('L'), COLLECT 8'hBF ('-'), UNLOCKED 8'hC1 ('U'), LOCKOUT 8'h88 ('A'); when ena=0, seg_out SHALL be 8'hFF and the FSM SHALL keep running.
REQ-014 All counters SHALL be sized with $clog2 of their terminal value, SHALL saturate (never wrap), and fail_cnt SHALL never exceed MAX_FAILS.

Reset
REQ-015 rst_n=0 SHALL asynchronously force LOCKED, index=0, mismatch=0, fail_cnt=0, timer=0, giving unlocked=0, alarm=0, key_ready=1, seg_out=8'hC7 (8'hFF if ena=0).
REQ-016 Reset asserted mid-COLLECT or mid-LOCKOUT SHALL discard all progress; no state SHALL survive reset.

Structure
REQ-017 Package sentinel_pkg SHALL hold the state enum and the four seg_out constants plus SEG_OFF 8'hFF.
REQ-018 A single sub-module sentinel_cycle_timer (loadable saturating down-counter, expiry flag) SHALL be shared by the timeout, lockout, and auto-relock functions, reloaded on every state entry and on every accepted symbol.

Verification
REQ-019 Defaults; symbols B6,5A,C3,0F on consecutive cycles -> unlocked=1 and seg_out=8'hC1 right after the 4th edge, fail_cnt=0.
REQ-020 Symbols B6,00,C3,0F -> no early abort, key_ready high throughout, LOCKED after the 4th edge, fail_cnt=1, seg_out=8'hC7.
REQ-021 Three wrong codes -> alarm=1, seg_out=8'h88, key_valid ignored for 1024 cycles, then LOCKED with fail_cnt=0.
REQ-022 Enter B6 then idle 256 cycles -> LOCKED with fail_cnt=1; repeat with B6 at gap 256 -> symbol accepted, no timeout.
REQ-023 In UNLOCKED, relock and key_valid together -> LOCKED, symbol dropped; in COLLECT, glitch pulse -> LOCKOUT with fail_cnt=3.
REQ-024 rst_n low mid-COLLECT -> immediate LOCKED with all outputs at REQ-015 values; ena=0 -> seg_out=8'hFF while the FSM still unlocks on the correct code.

Source files
------------

// File: rtl/sentinel_pkg.sv
// Shared state encoding, 7-segment glyphs and sizing helper for the sequence lock.
// Pure declarations: no latency, no backpressure.
package sentinel_pkg;

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_UNLOCKED = 2'd2,
    ST_LOCKOUT  = 2'd3
  } state_t;

  // Active-low glyphs, bit order {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] SEG_LOCKED   = 8'hC7;
  localparam logic [7:0] SEG_COLLECT  = 8'hBF;
  localparam logic [7:0] SEG_UNLOCKED = 8'hC1;
  localparam logic [7:0] SEG_LOCKOUT  = 8'h88;
  localparam logic [7:0] SEG_OFF      = 8'hFF;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sentinel_cycle_timer.sv
// Loadable saturating down-counter; o_expired is high while the count rests at zero.
// Latency: a load takes effect at the next edge; never stalls, no backpressure.
module sentinel_cycle_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/sentinel_seq_lock.sv
// Constant-time keypad sequence lock with failure lockout and glitch response.
// Latency: decision at the edge sampling the last symbol; key_ready drops outside LOCKED/COLLECT.
module sentinel_seq_lock
  import sentinel_pkg::*;
#(
  parameter int                         KEY_W          = 8,
  parameter int                         SEQ_LEN        = 4,
  parameter logic [SEQ_LEN*KEY_W-1:0]   KEY_SEQ        = {8'h0F, 8'hC3, 8'h5A, 8'hB6},
  parameter int                         MAX_FAILS      = 3,
  parameter int                         LOCKOUT_CYCLES = 1024,
  parameter int                         TIMEOUT_CYCLES = 256,
  parameter int                         AUTO_RELOCK    = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ena,
  input  logic [KEY_W-1:0]                 key_in,
  input  logic                             key_valid,
  output logic                             key_ready,
  input  logic                             relock,
  input  logic                             glitch,
  output logic [7:0]                       seg_out,
  output logic                             unlocked,
  output logic                             alarm,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt
);

  localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
  localparam int IDX_W   = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int TMR_MAX = max_of(max_of(LOCKOUT_CYCLES, TIMEOUT_CYCLES), max_of(AUTO_RELOCK, 2));
  localparam int TMR_W   = $clog2(TMR_MAX);

  localparam logic [FAIL_W-1:0] FAIL_MAX   = FAIL_W'(MAX_FAILS);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(SEQ_LEN - 1);
  localparam logic [TMR_W-1:0]  LD_TIMEOUT = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0]  LD_LOCKOUT = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0]  LD_AUTO    = TMR_W'((AUTO_RELOCK > 0) ? AUTO_RELOCK - 1 : 0);

  state_t              r_state;
  state_t              w_nxt_state;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_nxt_idx;
  logic                r_mis;
  logic                w_nxt_mis;
  logic [FAIL_W-1:0]   r_fail;
  logic [FAIL_W-1:0]   w_nxt_fail;
  logic [FAIL_W-1:0]   w_fail_inc;
  logic                w_tmr_load;
  logic [TMR_W-1:0]    w_tmr_val;
  logic                w_expired;
  logic                w_last;
  logic                w_mis_acc;
  logic [7:0]          w_seg;
  logic [KEY_W-1:0]    w_syms [SEQ_LEN];

  for (genvar g = 0; g < SEQ_LEN; g++) begin : g_sym
    assign w_syms[g] = KEY_SEQ[g*KEY_W +: KEY_W];
  end

  sentinel_cycle_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_expired  (w_expired)
  );

  // Index and mismatch are always zero in LOCKED, so one path covers first and later symbols.
  assign w_last     = (r_idx == IDX_LAST);
  assign w_mis_acc  = r_mis | (key_in != w_syms[r_idx]);
  assign w_fail_inc = (r_fail == FAIL_MAX) ? r_fail : r_fail + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_LOCKED;
      r_idx   <= '0;
      r_mis   <= 1'b0;
      r_fail  <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_idx   <= w_nxt_idx;
      r_mis   <= w_nxt_mis;
      r_fail  <= w_nxt_fail;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_nxt_mis   = r_mis;
    w_nxt_fail  = r_fail;
    w_tmr_load  = 1'b0;
    w_tmr_val   = LD_TIMEOUT;
    if (glitch) begin
      w_nxt_state = ST_LOCKOUT;
      w_nxt_idx   = '0;
      w_nxt_mis   = 1'b0;
      w_nxt_fail  = FAIL_MAX;
      w_tmr_load  = 1'b1;
      w_tmr_val   = LD_LOCKOUT;
    end else begin
      case (r_state)
        ST_LOCKED, ST_COLLECT: begin
          if (key_valid && !w_last) begin
            w_nxt_state = ST_COLLECT;
            w_nxt_idx   = r_idx + 1'b1;
            w_nxt_mis   = w_mis_acc;
            w_tmr_load  = 1'b1;
          end else if (key_valid || (r_state == ST_COLLECT && w_expired)) begin
            // A symbol on the expiry edge wins over the timeout.
            w_nxt_idx  = '0;
            w_nxt_mis  = 1'b0;
            w_tmr_load = 1'b1;
            if (key_valid && !w_mis_acc) begin
              w_nxt_state = ST_UNLOCKED;
              w_nxt_fail  = '0;
              w_tmr_val   = LD_AUTO;
            end else begin
              w_nxt_fail = w_fail_inc;
              if (w_fail_inc == FAIL_MAX) begin
                w_nxt_state = ST_LOCKOUT;
                w_tmr_val   = LD_LOCKOUT;
              end else begin
                w_nxt_state = ST_LOCKED;
              end
            end
          end
        end
        ST_UNLOCKED: begin
          if (relock || ((AUTO_RELOCK > 0) && w_expired)) begin
            w_nxt_state = ST_LOCKED;
            w_tmr_load  = 1'b1;
          end
        end
        ST_LOCKOUT: begin
          if (w_expired) begin
            w_nxt_state = ST_LOCKED;
            w_nxt_fail  = '0;
            w_tmr_load  = 1'b1;
          end
        end
        default: begin
          w_nxt_state = ST_LOCKED;
        end
      endcase
    end
  end

  always_comb begin
    w_seg = SEG_OFF;
    case (r_state)
      ST_LOCKED:   w_seg = SEG_LOCKED;
      ST_COLLECT:  w_seg = SEG_COLLECT;
      ST_UNLOCKED: w_seg = SEG_UNLOCKED;
      ST_LOCKOUT:  w_seg = SEG_LOCKOUT;
      default:     w_seg = SEG_OFF;
    endcase
  end

  assign seg_out   = ena ? w_seg : SEG_OFF;
  assign key_ready = (r_state == ST_LOCKED) || (r_state == ST_COLLECT);
  assign unlocked  = (r_state == ST_UNLOCKED);
  assign alarm     = (r_state == ST_LOCKOUT);
  assign fail_cnt  = r_fail;

endmodule

// File: tb/tb_sentinel_seq_lock.sv
// Directed bench for sentinel_seq_lock: a vector table for single-cycle behaviour,
// then hand sequences for lockout length, timeout boundary and asynchronous reset.
module tb_sentinel_seq_lock;

  localparam bit Y = 1'b1;
  localparam bit N = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] key_in;
  logic       key_valid;
  logic       key_ready;
  logic       relock;
  logic       glitch;
  logic [7:0] seg_out;
  logic       unlocked;
  logic       alarm;
  logic [1:0] fail_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sentinel_seq_lock dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .relock    (relock),
    .glitch    (glitch),
    .seg_out   (seg_out),
    .unlocked  (unlocked),
    .alarm     (alarm),
    .fail_cnt  (fail_cnt)
  );

  typedef struct {
    logic [7:0] key;
    logic       vld;
    logic       rel;
    logic       gl;
    logic       en;
    logic [7:0] seg;
    logic       unl;
    logic       al;
    logic       rdy;
    logic [1:0] fail;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic [7:0] k, input logic v, input logic r, input logic g,
                              input logic e, input logic [7:0] s, input logic u, input logic a,
                              input logic rd, input logic [1:0] f);
    vec_t t;
    t.key = k; t.vld = v; t.rel = r; t.gl = g; t.en = e;
    t.seg = s; t.unl = u; t.al = a; t.rdy = rd; t.fail = f;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] s, input logic u, input logic a,
                         input logic rd, input logic [1:0] f);
    chk({tag, " seg_out"},   32'(seg_out),   32'(s));
    chk({tag, " unlocked"},  32'(unlocked),  32'(u));
    chk({tag, " alarm"},     32'(alarm),     32'(a));
    chk({tag, " key_ready"}, 32'(key_ready), 32'(rd));
    chk({tag, " fail_cnt"},  32'(fail_cnt),  32'(f));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] k);
    key_in    = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic send_code(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] d);
    send(a); send(b); send(c); send(d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0]  = mk(8'hB6, Y, N, N, Y, 8'hBF, N, N, Y, 2'd0);
    tbl[1]  = mk(8'h5A, Y, N, N, Y, 8'hBF, N, N, Y, 2'd0);
    tbl[2]  = mk(8'hC3, Y, N, N, Y, 8'hBF, N, N, Y, 2'd0);
    tbl[3]  = mk(8'h0F, Y, N, N, Y, 8'hC1, Y, N, N, 2'd0);
    tbl[4]  = mk(8'h00, Y, N, N, Y, 8'hC1, Y, N, N, 2'd0);
    tbl[5]  = mk(8'hB6, Y, Y, N, Y, 8'hC7, N, N, Y, 2'd0);
    tbl[6]  = mk(8'h00, N, N, N, Y, 8'hC7, N, N, Y, 2'd0);
    tbl[7]  = mk(8'hB6, Y, N, N, Y, 8'hBF, N, N, Y, 2'd0);
    tbl[8]  = mk(8'h00, Y, N, N, Y, 8'hBF, N, N, Y, 2'd0);
    tbl[9]  = mk(8'hC3, Y, N, N, Y, 8'hBF, N, N, Y, 2'd0);
    tbl[10] = mk(8'h0F, Y, N, N, Y, 8'hC7, N, N, Y, 2'd1);
    tbl[11] = mk(8'h00, N, N, N, N, 8'hFF, N, N, Y, 2'd1);
    tbl[12] = mk(8'hB6, Y, N, N, N, 8'hFF, N, N, Y, 2'd1);
    tbl[13] = mk(8'h5A, Y, N, N, N, 8'hFF, N, N, Y, 2'd1);
    tbl[14] = mk(8'hC3, Y, N, N, N, 8'hFF, N, N, Y, 2'd1);
    tbl[15] = mk(8'h0F, Y, N, N, N, 8'hFF, Y, N, N, 2'd0);
    tbl[16] = mk(8'h00, N, Y, N, Y, 8'hC7, N, N, Y, 2'd0);
    tbl[17] = mk(8'hB6, Y, N, N, Y, 8'hBF, N, N, Y, 2'd0);
    tbl[18] = mk(8'h5A, Y, N, Y, Y, 8'h88, N, Y, N, 2'd3);

    rst_n = 1'b0; ena = 1'b0; key_in = 8'h00; key_valid = 1'b0; relock = 1'b0; glitch = 1'b0;
    #3;
    chk("reset ena0 seg_out", 32'(seg_out), 32'hFF);
    ena = 1'b1;
    #1;
    chk_out("reset", 8'hC7, N, N, Y, 2'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 19; i++) begin
      key_in = tbl[i].key; key_valid = tbl[i].vld; relock = tbl[i].rel;
      glitch = tbl[i].gl;  ena = tbl[i].en;
      tick();
      chk_out($sformatf("row%0d", i), tbl[i].seg, tbl[i].unl, tbl[i].al, tbl[i].rdy, tbl[i].fail);
    end
    key_valid = 1'b0; relock = 1'b0; glitch = 1'b0; ena = 1'b1;

    // Asynchronous reset in the middle of a lockout
    #2 rst_n = 1'b0;
    #1 chk_out("reset mid-lockout", 8'hC7, N, N, Y, 2'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Three wrong codes, then the full lockout window with a symbol held on the bus
    send_code(8'hB6, 8'h00, 8'hC3, 8'h0F);
    chk("wrong1 fail_cnt", 32'(fail_cnt), 32'd1);
    send_code(8'hB6, 8'h00, 8'hC3, 8'h0F);
    chk("wrong2 fail_cnt", 32'(fail_cnt), 32'd2);
    send_code(8'hB6, 8'h00, 8'hC3, 8'h0F);
    chk_out("lockout entry", 8'h88, N, Y, N, 2'd3);
    key_in = 8'hB6; key_valid = 1'b1;
    n = 0;
    repeat (1023) begin
      tick();
      if (alarm && !key_ready && fail_cnt == 2'd3) n++;
    end
    chk("lockout held cycles", 32'(n), 32'd1023);
    tick();
    key_valid = 1'b0;
    chk_out("lockout exit", 8'hC7, N, N, Y, 2'd0);

    // Inter-symbol timeout taken after 256 idle cycles
    send(8'hB6);
    repeat (255) tick();
    chk("timeout pre-expiry seg_out", 32'(seg_out), 32'hBF);
    tick();
    chk("timeout seg_out", 32'(seg_out), 32'hC7);
    chk("timeout fail_cnt", 32'(fail_cnt), 32'd1);

    // Symbol arriving exactly on the expiry edge is accepted instead
    send(8'hB6);
    repeat (255) tick();
    send(8'h5A);
    chk("gap256 seg_out", 32'(seg_out), 32'hBF);
    chk("gap256 fail_cnt", 32'(fail_cnt), 32'd1);
    send(8'hC3);
    send(8'h0F);
    chk("gap256 unlocked", 32'(unlocked), 32'd1);
    chk("gap256 fail_cnt after unlock", 32'(fail_cnt), 32'd0);
    relock = 1'b1;
    tick();
    relock = 1'b0;

    // Asynchronous reset mid-entry discards index, mismatch and failures
    send_code(8'hB6, 8'h00, 8'hC3, 8'h0F);
    chk("pre-reset fail_cnt", 32'(fail_cnt), 32'd1);
    send(8'hB6);
    send(8'h5A);
    #2 rst_n = 1'b0;
    #1 chk_out("reset mid-collect", 8'hC7, N, N, Y, 2'd0);
    tick();
    rst_n = 1'b1;
    send_code(8'hB6, 8'h5A, 8'hC3, 8'h0F);
    chk_out("unlock after reset", 8'hC1, Y, N, N, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
